dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single-ported 1K-word data memory between two requesters: port 0 (CPU load/store stage) and port 1 (debug/loader). Round-robin arbitration, one transaction in flight at a time. The block drives the memory's addr/dataIn/memoryEnable/readNotWrite and returns registered read data plus a per-port completion pulse. It sits between the requesters and the data memory, and is the only master of that memory.

Parameters:
ADDR_W, 32, requester/memory address width (word address)
DATA_W, 32, data width
MEM_DEPTH, 1024, number of valid words; addr >= MEM_DEPTH is out of range

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
req  in  2  per-port request; held with fields stable until gnt
we  in  2  per-port write enable (1 = write, 0 = read)
addr0, addr1  in  ADDR_W  port 0/1 address
wdata0, wdata1  in  DATA_W  port 0/1 write data
gnt  out  2  one-hot, 1-cycle pulse: request accepted
ack  out  2  one-hot, 1-cycle pulse: transaction complete
err  out  1  pulses with ack when the address was out of range
rdata  out  DATA_W  read data, valid while ack pulses for a read
busy  out  1  high in any state other than IDLE
mem_addr  out  ADDR_W  to memory addr
mem_wdata  out  DATA_W  to memory dataIn
mem_en  out  1  to memory memoryEnable
mem_rnw  out  1  to memory readNotWrite
mem_rdata  in  DATA_W  from memory dataOut (registered inside memory)

Behaviour:
- Reset values: gnt=0, ack=0, err=0, rdata=0, busy=0, mem_en=0, mem_rnw=1, mem_addr=0, mem_wdata=0; state=IDLE; rr pointer favours port 0.
- mem_rnw=1 in every state and cycle except ISSUE-for-write. The memory writes on every edge where readNotWrite=0, so this rule is mandatory.
- States:
  - IDLE: if any req, pick winner; gnt[winner]=1 (combinational this cycle); latch id/we/addr/wdata at the edge; go to ISSUE. With no req, stay in IDLE.
  - Out-of-range addr at latch: go to RESP directly with err flagged; no memory access.
  - ISSUE: mem_en=1, mem_addr/mem_wdata from latches, mem_rnw=~we_lat. At the edge, a write commits and goes to DONE; a read goes to RESP (the memory registers dataOut at this edge).
  - RESP: at the edge, rdata<=mem_rdata (or 0 if err); ack[id]<=1; err<=err_lat; go to IDLE.
  - DONE (write): at the edge, ack[id]<=1; go to IDLE.
- Latency from the gnt cycle: ack visible 3 cycles later for reads and writes (gnt, ISSUE, RESP/DONE, ack in IDLE). Ack and a new gnt may coincide.
- Round-robin: when both ports request, the port not granted last wins. The pointer updates on every gnt. A single requester always wins.
- Requester may drop req the cycle after gnt. Req held after ack is treated as a new request.
- rdata holds its last value until the next read ack. Write acks leave rdata unchanged.
- Reset mid-transaction aborts immediately: pending ack lost, memory write not performed unless the ISSUE edge already occurred.
- Simultaneous req from both ports in the ack cycle: normal round-robin applies.

Optional Feature:
DMEM_ARB_STATS_EN:
- Defined: adds input stats_clr and outputs gnt_cnt0 and gnt_cnt1 (16-bit each). Each counter increments on its port's gnt and saturates at 0xFFFF. stats_clr (synchronous) zeros both counters and wins over an increment in the same cycle. Reset zeros both.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package dmem_arb_pkg: state encoding (IDLE, ISSUE, RESP, DONE), port id constants (PORT_CPU=0, PORT_DBG=1), default widths and depth.
- One sub-module, rr_arbiter2: combinational req[1:0] + last-grant pointer -> one-hot grant, with the pointer register inside.

Test Plan:
- Port 0 write addr 5 data 0xDEADBEEF, then port 0 read addr 5 -> ack0 3 cycles after each gnt0, rdata=0xDEADBEEF with ack0, err=0.
- Both ports read (addr 1, addr 2) every cycle for 4 transactions -> gnt alternates 0,1,0,1 starting with port 0 after reset.
- Port 1 read addr 1024 -> ack1 with err=1, rdata=0, mem_en never asserted, mem_rnw stays 1.
- Idle for 20 cycles with random addr/wdata and req=0 -> mem_rnw=1 and mem_en=0 throughout; memory contents unchanged.
- Assert reset (0) during ISSUE of a read -> all outputs at reset values immediately, no ack; next request is served normally.
- DMEM_ARB_STATS_EN defined: 3 grants to port 0 then stats_clr with a simultaneous grant -> gnt_cnt0 goes 3 then 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter slice.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        DONE  = 2'd3
    } arbState_t;

    localparam int unsigned PORT_CPU = 0;
    localparam int unsigned PORT_DBG = 1;

    localparam int unsigned DEF_ADDR_W    = 32;
    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_MEM_DEPTH = 1024;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant from req plus a last-grant pointer.
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Pointer holds the id of the last granted port; reset favours the CPU port.
    logic lastId;

    always_comb begin
        gnt = '0;
        if (en) begin
            if (req[PORT_CPU] && req[PORT_DBG]) begin
                if (lastId == 1'(PORT_DBG)) gnt[PORT_CPU] = 1'b1;
                else                        gnt[PORT_DBG] = 1'b1;
            end else if (req[PORT_CPU]) begin
                gnt[PORT_CPU] = 1'b1;
            end else if (req[PORT_DBG]) begin
                gnt[PORT_DBG] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lastId <= 1'(PORT_DBG);
        end else if (|gnt) begin
            lastId <= gnt[PORT_DBG];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-ported data memory between two requesters.
// Optional grant counters enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        ack,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_en,
    output logic              mem_rnw,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [15:0]       gnt_cnt0,
    output logic [15:0]       gnt_cnt1
`endif
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);

    arbState_t         state, nextState;
    logic [1:0]        grant;
    logic              idLat, weLat, errLat;
    logic [ADDR_W-1:0] addrLat;
    logic [DATA_W-1:0] wdataLat;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selWdata;
    logic              selWe, outOfRange;

    rr_arbiter2 u_rr (
        .clk   (clk),
        .reset (reset),
        .en    (state == IDLE),
        .req   (req),
        .gnt   (grant)
    );

    assign gnt        = grant;
    assign selAddr    = grant[PORT_DBG] ? addr1  : addr0;
    assign selWdata   = grant[PORT_DBG] ? wdata1 : wdata0;
    assign selWe      = grant[PORT_DBG] ? we[PORT_DBG] : we[PORT_CPU];
    assign outOfRange = {1'b0, selAddr} >= DEPTH_L;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // readNotWrite is low only in ISSUE for a write: the memory writes on any such edge.
    always_comb begin
        nextState = state;
        busy      = (state != IDLE);
        mem_en    = 1'b0;
        mem_rnw   = 1'b1;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (|grant) nextState = outOfRange ? RESP : ISSUE;
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_rnw   = ~weLat;
                mem_addr  = addrLat;
                mem_wdata = wdataLat;
                nextState = weLat ? DONE : RESP;
            end
            RESP:    nextState = IDLE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idLat    <= 1'b0;
            weLat    <= 1'b0;
            errLat   <= 1'b0;
            addrLat  <= '0;
            wdataLat <= '0;
            ack      <= '0;
            err      <= 1'b0;
            rdata    <= '0;
        end else begin
            ack <= '0;
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        idLat    <= grant[PORT_DBG];
                        weLat    <= selWe;
                        errLat   <= outOfRange;
                        addrLat  <= selAddr;
                        wdataLat <= selWdata;
                    end
                end
                RESP: begin
                    rdata      <= errLat ? '0 : mem_rdata;
                    ack[idLat] <= 1'b1;
                    err        <= errLat;
                end
                DONE: begin
                    ack[idLat] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else if (stats_clr) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (grant[PORT_CPU] && gnt_cnt0 != '1) gnt_cnt0 <= gnt_cnt0 + 16'd1;
            if (grant[PORT_DBG] && gnt_cnt1 != '1) gnt_cnt1 <= gnt_cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural memory and reference model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req = '0;
    logic [1:0]  we = '0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic [1:0]  gnt, ack;
    logic        err, busy, mem_en, mem_rnw;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [31:0] memOut = '0;
`ifdef DMEM_ARB_STATS_EN
    logic        stats_clr = 1'b0;
    logic        statsClrNext = 1'b0;
    logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(1024)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .ack(ack), .err(err), .rdata(rdata), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_en(mem_en),
        .mem_rnw(mem_rnw), .mem_rdata(memOut)
`ifdef DMEM_ARB_STATS_EN
        , .stats_clr(stats_clr), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
    );

    always #5 clk = ~clk;

    // Memory: writes on every edge with readNotWrite low, registered read data.
    logic [31:0] memArr [1024] = '{default: '0};
    always @(posedge clk) begin
        if (!mem_rnw) memArr[mem_addr[9:0]] <= mem_wdata;
        if (mem_en && mem_rnw) memOut <= memArr[mem_addr[9:0]];
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        port;
        logic        isErr;
        logic [31:0] rdata;
        int unsigned ackCyc;
    } exp_t;
    exp_t sbQ[$];

    // Reference model state
    logic [31:0] refMem [1024] = '{default: '0};
    logic [31:0] lastRd = '0;
    logic        lastG = 1'b1;
    int unsigned freeCycle = 0;
    logic [1:0]  pend = '0, keep = '0;
    logic [1:0]  pWe = '0;
    logic [31:0] pAddr [2] = '{default: '0};
    logic [31:0] pData [2] = '{default: '0};
    logic        gLog[$];
    int unsigned enCount = 0;

    always @(negedge clk) begin
        if (reset) begin
            if (mem_en) enCount++;
            else chk("rnw_idle", {31'b0, mem_rnw}, 32'd1);
            if (ack != 2'b00) begin
                if (sbQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_ack: got ack=%b expected none (cycle %0d)", ack, cyc);
                end else begin
                    exp_t e;
                    e = sbQ.pop_front();
                    chk("ack_port", {30'b0, ack}, e.port ? 32'd2 : 32'd1);
                    chk("err", {31'b0, err}, {31'b0, e.isErr});
                    chk("rdata", rdata, e.rdata);
                    chk("ack_latency", cyc, e.ackCyc);
                end
            end else begin
                chk("err_no_ack", {31'b0, err}, 32'd0);
            end
        end
    end

    task automatic tick();
        logic [1:0] expG;
        logic       p;
        logic       isErr;
        exp_t       e;
        @(posedge clk);
        #1;
        req    = pend;
        we     = pWe;
        addr0  = pAddr[0];
        addr1  = pAddr[1];
        wdata0 = pData[0];
        wdata1 = pData[1];
`ifdef DMEM_ARB_STATS_EN
        stats_clr = statsClrNext;
`endif
        #1;
        expG = 2'b00;
        if (cyc >= freeCycle) begin
            if (pend == 2'b11)  expG = lastG ? 2'b01 : 2'b10;
            else if (pend[0])   expG = 2'b01;
            else if (pend[1])   expG = 2'b10;
        end
        chk("gnt", {30'b0, gnt}, {30'b0, expG});
        if (gnt != 2'b00) gLog.push_back(gnt[1]);
        if (expG != 2'b00) begin
            p     = expG[1];
            isErr = pAddr[p] >= 32'd1024;
            e.port  = p;
            e.isErr = isErr;
            if (isErr) begin
                e.rdata = '0;
                lastRd  = '0;
            end else if (!pWe[p]) begin
                e.rdata = refMem[pAddr[p][9:0]];
                lastRd  = e.rdata;
            end else begin
                refMem[pAddr[p][9:0]] = pData[p];
                e.rdata = lastRd;
            end
            e.ackCyc  = cyc + (isErr ? 2 : 3);
            freeCycle = e.ackCyc;
            lastG     = p;
            sbQ.push_back(e);
            if (!keep[p]) pend[p] = 1'b0;
        end
    endtask

    task automatic post(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        pend[p]  = 1'b1;
        pWe[p]   = w;
        pAddr[p] = a;
        pData[p] = d;
    endtask

    task automatic drain();
        int n = 0;
        while ((pend != 2'b00 || cyc <= freeCycle) && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) chk("drain_timeout", {30'b0, pend}, 32'd0);
    endtask

    task automatic chkResetOutputs(input string tag);
        chk({tag, "_gnt"}, {30'b0, gnt}, 32'd0);
        chk({tag, "_ack"}, {30'b0, ack}, 32'd0);
        chk({tag, "_err"}, {31'b0, err}, 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_mem_en"}, {31'b0, mem_en}, 32'd0);
        chk({tag, "_mem_rnw"}, {31'b0, mem_rnw}, 32'd1);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned enBefore;
        int n;
        logic [1:0] gnt01;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chkResetOutputs("reset");

        // Both ports read continuously: grants alternate starting with port 0.
        keep = 2'b11;
        post(0, 1'b0, 32'd1, 32'd0);
        post(1, 1'b0, 32'd2, 32'd0);
        n = 0;
        while (gLog.size() < 4 && n < 40) begin
            tick();
            n++;
        end
        keep = 2'b00;
        if (gLog.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("rr_sequence", {31'b0, gLog[i]}, i % 2);
        end else begin
            chk("rr_sequence_count", gLog.size(), 32'd4);
        end
        drain();

        // Write then read back on port 0.
        post(0, 1'b1, 32'd5, 32'hDEADBEEF);
        drain();
        post(0, 1'b0, 32'd5, 32'd0);
        drain();

        // Out-of-range read on port 1 never touches the memory.
        enBefore = enCount;
        post(1, 1'b0, 32'd1024, 32'd0);
        drain();
        chk("oor_no_mem_en", enCount - enBefore, 32'd0);

        // Idle with noisy address/data.
        enBefore = enCount;
        for (int i = 0; i < 20; i++) begin
            pWe      = 2'($urandom);
            pAddr[0] = $urandom;
            pAddr[1] = $urandom;
            pData[0] = $urandom;
            pData[1] = $urandom;
            tick();
        end
        chk("idle_no_mem_en", enCount - enBefore, 32'd0);

        // Reset during ISSUE of a read aborts without an ack.
        post(0, 1'b0, 32'd5, 32'd0);
        tick();
        @(posedge clk);
        #1;
        req = '0;
        chk("issue_busy", {31'b0, busy}, 32'd1);
        chk("issue_mem_en", {31'b0, mem_en}, 32'd1);
        reset = 1'b0;
        #1;
        chkResetOutputs("midreset");
        sbQ.delete();
        freeCycle = 0;
        lastG = 1'b1;
        lastRd = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        post(1, 1'b0, 32'd5, 32'd0);
        drain();

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 9) == 0)
                        post(p, 1'b0, 32'd1024 + $urandom_range(0, 5000), $urandom);
                    else
                        post(p, 1'($urandom), $urandom_range(0, 15), $urandom);
                end
            end
            tick();
        end
        drain();

`ifdef DMEM_ARB_STATS_EN
        statsClrNext = 1'b1;
        tick();
        statsClrNext = 1'b0;
        for (int i = 0; i < 3; i++) begin
            post(0, 1'b0, 32'd7, 32'd0);
            drain();
        end
        chk("gnt_cnt0_three", {16'b0, gnt_cnt0}, 32'd3);
        chk("gnt_cnt1_zero", {16'b0, gnt_cnt1}, 32'd0);
        post(0, 1'b0, 32'd7, 32'd0);
        statsClrNext = 1'b1;
        tick();
        statsClrNext = 1'b0;
        tick();
        chk("gnt_cnt0_cleared", {16'b0, gnt_cnt0}, 32'd0);
        drain();
`endif

        repeat (3) tick();
        chk("sb_empty", sbQ.size(), 32'd0);
        n = 0;
        for (int i = 0; i < 1024; i++) if (memArr[i] !== refMem[i]) n++;
        chk("mem_contents_diff", n, 32'd0);
        gnt01 = gnt;
        chk("final_gnt_idle", {30'b0, gnt01}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
